// File: rtl/sd_cmd_engine.sv
// SD command-line engine: serialises a 48-bit command frame with CRC7 and captures the 48/136-bit response.
// Optional build macro SD_CMD_CRC_CHECK_EN enables receive-side CRC7 checking (err_crc tied 0 otherwise).
module sd_cmd_engine #(
  parameter int HALF_DIV = 4,
  parameter int NCR_MAX  = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cmd_start,
  input  logic [5:0]   i_cmd_index,
  input  logic [31:0]  i_cmd_arg,
  input  logic [1:0]   i_rsp_type,
  output logic         o_busy,
  output logic         o_done,
  output logic [5:0]   o_rsp_index,
  output logic [127:0] o_rsp_data,
  output logic         o_err_timeout,
  output logic         o_err_crc,
  output logic         o_err_end,
  output logic         o_sd_clk,
  inout  wire          io_sd_cmd,
  output logic [2:0]   o_dbg_state
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TX   = 3'd1,
    S_TURN = 3'd2,
    S_RX   = 3'd3,
    S_NCC  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_div;
  logic           r_sdclk;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_type;
  logic [39:0]    r_tx_sh;
  logic [6:0]     r_crc;
  logic [5:0]     r_rsp_index;
  logic [127:0]   r_rsp_data;
  logic           r_err_timeout;
  logic           r_err_end;
  logic           r_done;

  logic           w_tick;
  logic           w_rise;
  logic           w_fall;
  logic           w_accept;
  logic           w_rx_bit;
  logic           w_rx_last;
  logic           w_tx_bit;
  logic           w_cnt_evt;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ({7{c[6] ^ b}} & 7'h09);
  endfunction

  // Request/ack: i_cmd_start is a request taken on any edge where the engine is idle and not
  // pulsing done; o_busy rises the cycle after acceptance and falls in the cycle o_done pulses.
  assign w_accept = (r_state == S_IDLE) && !r_done && i_cmd_start;

  // A tick marks the clk edge where sd_clk toggles; the bit boundary is the falling tick.
  assign w_tick    = (r_state != S_IDLE) && (r_div == 8'(HALF_DIV - 1));
  assign w_rise    = w_tick && !r_sdclk;
  assign w_fall    = w_tick && r_sdclk;
  assign w_rx_bit  = io_sd_cmd;
  assign w_rx_last = (r_type == 2'b10) ? (r_cnt == 16'd134) : (r_cnt == 16'd46);
  assign w_cnt_evt = (r_state == S_TX) ? w_fall : w_rise;

  assign w_tx_bit  = (r_cnt < 16'd40) ? r_tx_sh[39] :
                     (r_cnt < 16'd47) ? r_crc[6] : 1'b1;
  assign io_sd_cmd = (r_state == S_TX) ? w_tx_bit : 1'bz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_TX;
      S_TX:   if (w_fall && r_cnt == 16'd47) w_next = (r_type == 2'b00) ? S_NCC : S_TURN;
      S_TURN: begin
        if (w_rise) begin
          if (!w_rx_bit)                          w_next = S_RX;
          else if (r_cnt == CW'(NCR_MAX - 1))     w_next = S_NCC;
        end
      end
      S_RX:   if (w_rise && w_rx_last) w_next = S_NCC;
      // NCC counts 8 rising edges then ends on the following falling edge: 8 full idle periods.
      S_NCC:  if (w_fall && r_cnt == 16'd8) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef SD_CMD_CRC_CHECK_EN
  logic r_err_crc;
  logic w_crc_en;
  // R2 CRC covers the 120 payload bits after the header; 48-bit types cover transmission bit to argument.
  assign w_crc_en  = (r_type == 2'b10) ? (r_cnt >= 16'd7 && r_cnt <= 16'd126) : (r_cnt <= 16'd38);
  assign o_err_crc = r_err_crc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_crc <= 1'b0;
    end else if (w_accept) begin
      r_err_crc <= 1'b0;
    end else if (r_state == S_RX && w_rise && w_rx_last) begin
      r_err_crc <= (r_type != 2'b11) && (r_crc != r_rsp_data[6:0]);
    end
  end
`else
  assign o_err_crc = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div         <= 8'd0;
      r_sdclk       <= 1'b0;
      r_cnt         <= '0;
      r_type        <= 2'b00;
      r_tx_sh       <= '0;
      r_crc         <= 7'd0;
      r_rsp_index   <= 6'd0;
      r_rsp_data    <= '0;
      r_err_timeout <= 1'b0;
      r_err_end     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= (r_state == S_NCC) && (w_next == S_IDLE);

      if (r_state == S_IDLE) begin
        r_div   <= 8'd0;
        r_sdclk <= 1'b0;
      end else if (w_tick) begin
        r_div   <= 8'd0;
        r_sdclk <= ~r_sdclk;
      end else begin
        r_div   <= r_div + 8'd1;
      end

      if (w_next != r_state)                     r_cnt <= '0;
      else if (r_state != S_IDLE && w_cnt_evt)   r_cnt <= r_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_type        <= i_rsp_type;
            r_tx_sh       <= {2'b01, i_cmd_index, i_cmd_arg};
            r_crc         <= 7'd0;
            r_rsp_index   <= 6'd0;
            r_rsp_data    <= '0;
            r_err_timeout <= 1'b0;
            r_err_end     <= 1'b0;
          end
        end
        S_TX: begin
          if (w_fall) begin
            if (r_cnt < 16'd40) begin
              r_crc   <= crc7_step(r_crc, r_tx_sh[39]);
              r_tx_sh <= {r_tx_sh[38:0], 1'b0};
            end else if (r_cnt < 16'd47) begin
              r_crc   <= {r_crc[5:0], 1'b0};
            end else begin
              r_crc   <= 7'd0;
            end
          end
        end
        S_TURN: begin
          if (w_rise && w_rx_bit && r_cnt == CW'(NCR_MAX - 1)) r_err_timeout <= 1'b1;
        end
        S_RX: begin
          if (w_rise) begin
            if (r_cnt >= 16'd1 && r_cnt <= 16'd6) r_rsp_index <= {r_rsp_index[4:0], w_rx_bit};
            if (r_cnt >= 16'd7)                   r_rsp_data  <= {r_rsp_data[126:0], w_rx_bit};
`ifdef SD_CMD_CRC_CHECK_EN
            if (w_crc_en) r_crc <= crc7_step(r_crc, w_rx_bit);
`endif
            if (w_rx_last) r_err_end <= !w_rx_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_rsp_index   = r_rsp_index;
  assign o_rsp_data    = r_rsp_data;
  assign o_err_timeout = r_err_timeout;
  assign o_err_end     = r_err_end;
  assign o_sd_clk      = r_sdclk;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: a card model on the command line, expected results queued at stimulus time.
module tb_sd_cmd_engine;

  localparam int EW = 137;
`ifdef SD_CMD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   rsp_type;
  logic         busy, done, err_timeout, err_crc, err_end, sd_clk;
  logic [5:0]   rsp_index;
  logic [127:0] rsp_data;
  logic [2:0]   dbg_state;
  wire          sd_cmd;
  logic         card_oe;
  logic         card_bit;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [EW-1:0] exp_q[$];

  assign sd_cmd = card_oe ? card_bit : 1'bz;
  pullup (sd_cmd);

  sd_cmd_engine dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_start(cmd_start), .i_cmd_index(cmd_index),
    .i_cmd_arg(cmd_arg), .i_rsp_type(rsp_type), .o_busy(busy), .o_done(done),
    .o_rsp_index(rsp_index), .o_rsp_data(rsp_data), .o_err_timeout(err_timeout),
    .o_err_crc(err_crc), .o_err_end(err_end), .o_sd_clk(sd_clk), .io_sd_cmd(sd_cmd),
    .o_dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int n);
    logic [6:0] c;
    logic fb;
    c = 7'd0;
    for (int i = 0; i < n; i++) begin
      fb = c[6] ^ v[hi - i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] mk48(input logic tbit, input logic [5:0] i, input logic [31:0] a);
    logic [135:0] v;
    v = '0;
    v[39:0] = {1'b0, tbit, i, a};
    return {1'b0, tbit, i, a, crc7(v, 39, 40), 1'b1};
  endfunction

  function automatic logic [EW-1:0] mk_exp(input logic [5:0] i, input logic [127:0] d,
                                           input logic t, input logic c, input logic e);
    return {i, d, t, c, e};
  endfunction

  task automatic wait_rise(output bit ok);
    logic p;
    p  = sd_clk;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (p === 1'b0 && sd_clk === 1'b1) begin
        ok = 1'b1;
        break;
      end
      p = sd_clk;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL sd_clk_rise: no rising edge within 64 cycles, required one");
    end
  endtask

  // Caller must be at a negedge. Returns one cycle after the done pulse (or in it, if collide).
  task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] typ, input bit reply, input logic [135:0] rsp,
                         input int rsp_len, input logic [EW-1:0] exp, input bit mid_start,
                         input bit collide, output int dt, output logic [47:0] frame);
    bit ok;
    int t0;
    logic [EW-1:0] e;
    dt = -1;
    frame = '0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle_before: busy=%b required 0", name, busy); end
    cmd_index = idx; cmd_arg = arg; rsp_type = typ; cmd_start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_start = 1'b0;
    t0 = cyc;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_accept: busy=%b required 1", name, busy); end
    n_tests++;
    if (sd_cmd !== 1'b0) begin n_fail++; $display("FAIL %s start_bit: sd_cmd=%b required 0", name, sd_cmd); end
    for (int b = 0; b < 48; b++) begin
      wait_rise(ok);
      if (!ok) begin void'(exp_q.pop_back()); return; end
      frame = {frame[46:0], sd_cmd};
    end
    n_tests++;
    if (frame !== mk48(1'b1, idx, arg)) begin
      n_fail++; $display("FAIL %s frame: got %h required %h", name, frame, mk48(1'b1, idx, arg));
    end
    if (reply) begin
      wait_rise(ok);
      wait_rise(ok);
      for (int i = 0; i < rsp_len; i++) begin
        card_bit = rsp[rsp_len - 1 - i];
        card_oe  = 1'b1;
        if (mid_start && i == 60) begin
          cmd_index = 6'd5; cmd_arg = 32'hDEAD_BEEF; rsp_type = 2'b00; cmd_start = 1'b1;
          @(negedge clk);
          cmd_start = 1'b0;
        end
        wait_rise(ok);
        if (!ok) break;
      end
      card_oe = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL %s done_wait: done=0 after 3000 cycles, required a pulse", name);
      void'(exp_q.pop_back());
      return;
    end
    dt = cyc - t0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: busy=%b required 0", name, busy); end
    e = exp_q.pop_front();
    n_tests++;
    if (rsp_index !== e[136:131]) begin n_fail++; $display("FAIL %s rsp_index: got %h required %h", name, rsp_index, e[136:131]); end
    n_tests++;
    if (rsp_data !== e[130:3]) begin n_fail++; $display("FAIL %s rsp_data: got %h required %h", name, rsp_data, e[130:3]); end
    n_tests++;
    if (err_timeout !== e[2]) begin n_fail++; $display("FAIL %s err_timeout: got %b required %b", name, err_timeout, e[2]); end
    n_tests++;
    if (err_crc !== e[1]) begin n_fail++; $display("FAIL %s err_crc: got %b required %b", name, err_crc, e[1]); end
    n_tests++;
    if (err_end !== e[0]) begin n_fail++; $display("FAIL %s err_end: got %b required %b", name, err_end, e[0]); end
    if (collide) begin
      cmd_start = 1'b1;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL %s collide_ignored: busy=%b done=%b required 0 0", name, busy, done);
      end
    end else begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL %s done_one_cycle: done=%b busy=%b required 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; rsp_type = '0;
    card_oe = 1'b0; card_bit = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sd_clk !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b sd_clk=%b required 0 0 0", busy, done, sd_clk);
    end
    n_tests++;
    if (rsp_index !== 6'd0 || rsp_data !== 128'd0) begin
      n_fail++; $display("FAIL reset_rsp: index=%h data=%h required 0 0", rsp_index, rsp_data);
    end
    n_tests++;
    if ({err_timeout, err_crc, err_end} !== 3'b000) begin
      n_fail++; $display("FAIL reset_err: flags=%b required 000", {err_timeout, err_crc, err_end});
    end
    n_tests++;
    if (dbg_state !== 3'd0 || sd_cmd !== 1'b1) begin
      n_fail++; $display("FAIL reset_line: state=%0d sd_cmd=%b required 0 1(released)", dbg_state, sd_cmd);
    end
  endtask

  task automatic test_cmd0;
    int dt;
    logic [47:0] fr;
    @(negedge clk);
    run_cmd("cmd0", 6'd0, 32'd0, 2'b00, 1'b0, '0, 0, mk_exp(6'd0, '0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, dt, fr);
    n_tests++;
    if (fr !== 48'h400000000095) begin n_fail++; $display("FAIL cmd0_stream: got %h required 400000000095", fr); end
    n_tests++;
    if (dt !== 448) begin n_fail++; $display("FAIL cmd0_latency: done at T0+%0d required T0+449", dt + 1); end
  endtask

  task automatic test_cmd8;
    int dt;
    logic [47:0] fr, r;
    r = mk48(1'b0, 6'd8, 32'h1AA);
    @(negedge clk);
    run_cmd("cmd8", 6'd8, 32'h1AA, 2'b01, 1'b1, {88'd0, r}, 48,
            mk_exp(6'd8, {88'd0, r[39:0]}, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, dt, fr);
    n_tests++;
    if (fr !== 48'h48000001AA87) begin n_fail++; $display("FAIL cmd8_frame: got %h required 48000001AA87", fr); end
  endtask

  task automatic test_crc_errors;
    int dt;
    logic [47:0] fr, r, bad;
    r   = mk48(1'b0, 6'd17, 32'h0000_0900);
    bad = r ^ 48'h2;
    @(negedge clk);
    run_cmd("crc_flip_r1", 6'd17, 32'h1234, 2'b01, 1'b1, {88'd0, bad}, 48,
            mk_exp(6'd17, {88'd0, bad[39:0]}, 1'b0, CRC_EN, 1'b0), 1'b0, 1'b0, dt, fr);
    run_cmd("crc_flip_r3", 6'd41, 32'h40FF_8000, 2'b11, 1'b1, {88'd0, bad}, 48,
            mk_exp(6'd17, {88'd0, bad[39:0]}, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, dt, fr);
    bad = r & ~48'h1;
    run_cmd("end_zero", 6'd17, 32'h1234, 2'b01, 1'b1, {88'd0, bad}, 48,
            mk_exp(6'd17, {88'd0, bad[39:0]}, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, dt, fr);
  endtask

  task automatic test_no_card;
    int dt;
    logic [47:0] fr;
    @(negedge clk);
    run_cmd("no_card", 6'd55, 32'd0, 2'b01, 1'b0, '0, 0,
            mk_exp(6'd0, '0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, dt, fr);
    // 48 TX periods, 64 rising edges in TURN, half period to the fall, then 8 NCC periods
    n_tests++;
    if (dt !== 960) begin n_fail++; $display("FAIL no_card_latency: done at T0+%0d required T0+961", dt + 1); end
  endtask

  task automatic test_r2;
    int dt;
    logic [47:0] fr;
    logic [127:0] d;
    logic [135:0] v;
    v = '0;
    v[127:8] = 120'h0123456789ABCDEFFEDCBA98765432;
    d = {v[127:8], crc7(v, 127, 120), 1'b1};
    @(negedge clk);
    run_cmd("r2", 6'd2, 32'd0, 2'b10, 1'b1, {2'b00, 6'h3F, d}, 136,
            mk_exp(6'h3F, d, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, dt, fr);
  endtask

  task automatic test_reset_mid;
    int dt;
    logic [47:0] fr;
    bit seen;
    @(negedge clk);
    cmd_index = 6'd8; cmd_arg = 32'h1AA; rsp_type = 2'b01; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (sd_clk !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: sd_clk=%b busy=%b required 1 1", sd_clk, busy);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || sd_clk !== 1'b0 || done !== 1'b0 || dbg_state !== 3'd0 || sd_cmd !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b sd_clk=%b done=%b state=%0d sd_cmd=%b required 0 0 0 0 1",
               busy, sd_clk, done, dbg_state, sd_cmd);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL mid_reset_quiet: activity after reset seen=1 required 0"); end
    run_cmd("after_reset", 6'd0, 32'd0, 2'b00, 1'b0, '0, 0, mk_exp(6'd0, '0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, dt, fr);
    n_tests++;
    if (dt !== 448) begin n_fail++; $display("FAIL after_reset_latency: done at T0+%0d required T0+449", dt + 1); end
  endtask

  task automatic test_back_to_back;
    int dt;
    logic [47:0] fr;
    @(negedge clk);
    run_cmd("b2b_first", 6'd0, 32'd0, 2'b00, 1'b0, '0, 0, mk_exp(6'd0, '0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, dt, fr);
    run_cmd("b2b_second", 6'd9, 32'hA5A5_0F0F, 2'b00, 1'b0, '0, 0, mk_exp(6'd0, '0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, dt, fr);
    n_tests++;
    if (dt !== 448) begin n_fail++; $display("FAIL b2b_latency: done at T0+%0d required T0+449", dt + 1); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_crc_errors();
    test_no_card();
    test_r2();
    test_reset_mid();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
